// File: rtl/dmem_arbiter_if.sv
// Two-port data memory arbiter bus bundle.
// Carries both requester ports (req/we/addr/wdata in, gnt/rvalid/rdata/err out)
// and the single shared memory port (mem_A/mem_WD/mem_WE out, mem_RD in).
//   slave  : arbiter side
//   master : requesters + memory side (testbench / surrounding system)
interface dmem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        p1_err;

  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_RD,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_A, mem_WD, mem_WE
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_RD,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shared data memory arbiter: core port p0 and loader/DMA port p1 share one
// single-port memory with combinational read data.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - dmem_arbiter_if.slave (both requester ports and the memory port)
// One access is accepted per rising edge. The accepted access occupies the
// following (BUSY) cycle on the memory port; writes commit and read data is
// captured on the edge that ends that cycle, giving rvalid one cycle later.
// Addresses >= DEPTH are flagged with err, never written, and read as zero.
// Optional feature: define DMEM_ARB_RR_EN for round-robin tie breaking;
// without it p0 has fixed priority.
module dmem_arbiter #(
  parameter int unsigned DEPTH = 1024
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned AW      = 32;
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic          any_req_c;
  logic          p1_win_c;
  logic          sel_we_c;
  logic          sel_oor_c;
  logic [AW-1:0] sel_addr_c;
  logic [AW-1:0] sel_wdata_c;

  // Attributes of the access currently on the memory port
  logic          lat_p1;
  logic          lat_we;
  logic          lat_oor;

`ifdef DMEM_ARB_RR_EN
  // Set when p1 was the most recent winner; reset value lets p0 win first tie
  logic          last_p1;
`endif

  // Arbitration and winner mux
  always_comb begin
    any_req_c = bus.p0_req | bus.p1_req;
`ifdef DMEM_ARB_RR_EN
    p1_win_c  = bus.p1_req & (~bus.p0_req | ~last_p1);
`else
    p1_win_c  = bus.p1_req & ~bus.p0_req;
`endif
    sel_we_c    = p1_win_c ? bus.p1_we    : bus.p0_we;
    sel_addr_c  = p1_win_c ? bus.p1_addr  : bus.p0_addr;
    sel_wdata_c = p1_win_c ? bus.p1_wdata : bus.p0_wdata;
    sel_oor_c   = (sel_addr_c >= DEPTH_W);
  end

  // Accept / BUSY sequencing with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      lat_p1        <= 1'b0;
      lat_we        <= 1'b0;
      lat_oor       <= 1'b0;
      bus.p0_gnt    <= 1'b0;
      bus.p1_gnt    <= 1'b0;
      bus.p0_err    <= 1'b0;
      bus.p1_err    <= 1'b0;
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rdata  <= '0;
      bus.mem_A     <= '0;
      bus.mem_WD    <= '0;
      bus.mem_WE    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_p1       <= 1'b1;
`endif
    end else begin
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.p0_gnt    <= 1'b0;
      bus.p1_gnt    <= 1'b0;
      bus.p0_err    <= 1'b0;
      bus.p1_err    <= 1'b0;
      bus.mem_WE    <= 1'b0;

      // Close out the read that occupied the cycle ending at this edge
      if (state == BUSY && !lat_we) begin
        if (lat_p1) begin
          bus.p1_rvalid <= 1'b1;
          bus.p1_rdata  <= lat_oor ? '0 : bus.mem_RD;
        end else begin
          bus.p0_rvalid <= 1'b1;
          bus.p0_rdata  <= lat_oor ? '0 : bus.mem_RD;
        end
      end

      if (any_req_c) begin
        state      <= BUSY;
        lat_p1     <= p1_win_c;
        lat_we     <= sel_we_c;
        lat_oor    <= sel_oor_c;
        bus.p0_gnt <= ~p1_win_c;
        bus.p1_gnt <= p1_win_c;
        bus.p0_err <= ~p1_win_c & sel_oor_c;
        bus.p1_err <= p1_win_c & sel_oor_c;
        bus.mem_A  <= sel_addr_c;
        bus.mem_WD <= sel_wdata_c;
        bus.mem_WE <= sel_we_c & ~sel_oor_c;
`ifdef DMEM_ARB_RR_EN
        last_p1    <= p1_win_c;
`endif
      end else begin
        state      <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// transaction-level model compared against the DUT on every cycle out of reset.
module tb_dmem_arbiter;
  localparam int unsigned DEPTH = 1024;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();
  dmem_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Memory attached to the arbiter's memory port
  logic [31:0] env_mem [0:DEPTH-1];
  assign bus.mem_RD = (bus.mem_A < 32'(DEPTH)) ? env_mem[bus.mem_A[9:0]] : 32'hBAD0BAD0;
  always @(posedge clk) if (bus.mem_WE) env_mem[bus.mem_A[9:0]] <= bus.mem_WD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] ref_mem [0:DEPTH-1];
  bit          e_gnt [2];
  bit          e_err [2];
  bit          e_rv  [2];
  logic [31:0] e_rd  [2];
  bit          e_we;
  logic [31:0] e_a, e_wd;
  bit          pend;
  int          pend_port;
  bit          pend_we, pend_oor;
  int          pend_addr;
  logic [31:0] pend_wd;
  bit          p1_turn;

  always @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        e_gnt[p] = 0; e_err[p] = 0; e_rv[p] = 0; e_rd[p] = '0;
      end
      e_we = 0; pend = 0; p1_turn = 0;
    end else begin
      bit r0, r1, oor, we;
      int win;
      logic [31:0] a, wd;
      for (int p = 0; p < 2; p++) begin
        e_gnt[p] = 0; e_err[p] = 0; e_rv[p] = 0;
      end
      e_we = 0;
      // retire the access accepted on the previous edge
      if (pend) begin
        if (pend_we) begin
          if (!pend_oor) ref_mem[pend_addr] = pend_wd;
        end else begin
          e_rv[pend_port] = 1;
          e_rd[pend_port] = pend_oor ? 32'h0 : ref_mem[pend_addr];
        end
      end
      pend = 0;
      r0 = bus.p0_req;
      r1 = bus.p1_req;
      if (r0 || r1) begin
        if (r0 && r1) win = (RR && p1_turn) ? 1 : 0;
        else          win = r1 ? 1 : 0;
        p1_turn = (win == 0);
        we  = (win == 1) ? bus.p1_we    : bus.p0_we;
        a   = (win == 1) ? bus.p1_addr  : bus.p0_addr;
        wd  = (win == 1) ? bus.p1_wdata : bus.p0_wdata;
        oor = (a >= 32'(DEPTH));
        e_gnt[win] = 1;
        e_err[win] = oor;
        e_we = we && !oor;
        e_a  = a;
        e_wd = wd;
        pend = 1; pend_port = win; pend_we = we; pend_oor = oor;
        pend_addr = oor ? 0 : int'(a[9:0]);
        pend_wd = wd;
      end
      #1;
      if (rst) begin
        chk("m_p0_gnt",    32'(bus.p0_gnt),    32'(e_gnt[0]));
        chk("m_p1_gnt",    32'(bus.p1_gnt),    32'(e_gnt[1]));
        chk("m_p0_err",    32'(bus.p0_err),    32'(e_err[0]));
        chk("m_p1_err",    32'(bus.p1_err),    32'(e_err[1]));
        chk("m_p0_rvalid", 32'(bus.p0_rvalid), 32'(e_rv[0]));
        chk("m_p1_rvalid", 32'(bus.p1_rvalid), 32'(e_rv[1]));
        chk("m_p0_rdata",  bus.p0_rdata,       e_rd[0]);
        chk("m_p1_rdata",  bus.p1_rdata,       e_rd[1]);
        chk("m_mem_WE",    32'(bus.mem_WE),    32'(e_we));
        if (e_gnt[0] || e_gnt[1]) begin
          chk("m_mem_A",  bus.mem_A,  e_a);
          chk("m_mem_WD", bus.mem_WD, e_wd);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_port(input int p, input bit req, input bit we,
                          input logic [31:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
    end
  endtask

  task automatic idle_all();
    set_port(0, 0, 0, 32'h0, 32'h0);
    set_port(1, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      env_mem[i] = 32'h1000_0000 + 32'(i);
      ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    rst = 1'b0;
    idle_all();

    // reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_p0_gnt",    32'(bus.p0_gnt),    32'h0);
    chk("rst_p1_gnt",    32'(bus.p1_gnt),    32'h0);
    chk("rst_rvalid",    32'({bus.p0_rvalid, bus.p1_rvalid}), 32'h0);
    chk("rst_err",       32'({bus.p0_err, bus.p1_err}), 32'h0);
    chk("rst_p0_rdata",  bus.p0_rdata, 32'h0);
    chk("rst_p1_rdata",  bus.p1_rdata, 32'h0);
    chk("rst_mem_A",     bus.mem_A,  32'h0);
    chk("rst_mem_WD",    bus.mem_WD, 32'h0);
    chk("rst_mem_WE",    32'(bus.mem_WE), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // p0 write 240 then read it back
    @(negedge clk);
    set_port(0, 1, 1, 32'd240, 32'h0000_0020);
    after_edge();
    chk("w240_gnt",   32'(bus.p0_gnt), 32'h1);
    chk("w240_we",    32'(bus.mem_WE), 32'h1);
    chk("w240_addr",  bus.mem_A, 32'd240);
    @(negedge clk);
    set_port(0, 1, 0, 32'd240, 32'h0);
    after_edge();
    chk("r240_gnt",   32'(bus.p0_gnt), 32'h1);
    chk("r240_we",    32'(bus.mem_WE), 32'h0);
    chk("r240_early", 32'(bus.p0_rvalid), 32'h0);
    @(negedge clk);
    idle_all();
    after_edge();
    chk("r240_rvalid", 32'(bus.p0_rvalid), 32'h1);
    chk("r240_rdata",  bus.p0_rdata, 32'h0000_0020);
    chk("r240_nognt",  32'(bus.p0_gnt), 32'h0);

    // both ports hold reads
    do_reset();
    @(negedge clk);
    set_port(0, 1, 0, 32'd10, 32'h0);
    set_port(1, 1, 0, 32'd20, 32'h0);
    for (int k = 0; k < 6; k++) begin
      bit exp0;
      after_edge();
      exp0 = RR ? (k % 2 == 0) : 1'b1;
      chk("hold_p0_gnt", 32'(bus.p0_gnt), 32'(exp0));
      chk("hold_p1_gnt", 32'(bus.p1_gnt), 32'(!exp0));
    end
    @(negedge clk);
    idle_all();
    repeat (3) after_edge();

    // p1 out-of-range write then read
    @(negedge clk);
    set_port(1, 1, 1, 32'd1024, 32'hDEAD_BEEF);
    after_edge();
    chk("oorw_gnt", 32'(bus.p1_gnt), 32'h1);
    chk("oorw_err", 32'(bus.p1_err), 32'h1);
    chk("oorw_we",  32'(bus.mem_WE), 32'h0);
    @(negedge clk);
    set_port(1, 1, 0, 32'd1024, 32'h0);
    after_edge();
    chk("oorr_err", 32'(bus.p1_err), 32'h1);
    @(negedge clk);
    idle_all();
    after_edge();
    chk("oorr_rvalid", 32'(bus.p1_rvalid), 32'h1);
    chk("oorr_rdata",  bus.p1_rdata, 32'h0);

    // reset during a BUSY write aborts it
    @(negedge clk);
    set_port(0, 1, 1, 32'd5, 32'hCAFE_0005);
    after_edge();
    chk("abort_we_before", 32'(bus.mem_WE), 32'h1);
    #1;
    rst = 1'b0;
    idle_all();
    #1;
    chk("abort_we_now",  32'(bus.mem_WE), 32'h0);
    chk("abort_gnt_now", 32'(bus.p0_gnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_port(0, 1, 0, 32'd5, 32'h0);
    after_edge();
    chk("abort_rd_gnt", 32'(bus.p0_gnt), 32'h1);
    @(negedge clk);
    idle_all();
    after_edge();
    chk("abort_rvalid", 32'(bus.p0_rvalid), 32'h1);
    chk("abort_old",    bus.p0_rdata, 32'h1000_0005);

    // same-edge p0 write / p1 read of address 7
    do_reset();
    @(negedge clk);
    set_port(0, 1, 1, 32'd7, 32'h0000_0011);
    set_port(1, 1, 0, 32'd7, 32'h0);
    after_edge();
    chk("tie_p0_first", 32'(bus.p0_gnt), 32'h1);
    chk("tie_p1_wait",  32'(bus.p1_gnt), 32'h0);
    @(negedge clk);
    set_port(0, 0, 0, 32'h0, 32'h0);
    after_edge();
    chk("tie_p1_gnt", 32'(bus.p1_gnt), 32'h1);
    @(negedge clk);
    idle_all();
    after_edge();
    chk("tie_p1_rvalid", 32'(bus.p1_rvalid), 32'h1);
    chk("tie_p1_rdata",  bus.p1_rdata, 32'h0000_0011);

    repeat (2) after_edge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
